// File: rtl/rtc_date.sv
// BCD calendar date counter (day/month/year) with Gregorian leap years.
// Optional weekday register enabled by defining RTC_DATE_WEEKDAY_EN.
module rtc_date (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        new_day_i,
   input  logic        date_update_i,
   input  logic [31:0] date_i,
   input  logic [2:0]  weekday_i,
   output logic [31:0] date_o,
   output logic [2:0]  weekday_o,
   output logic        new_month_o,
   output logic        new_year_o
);

   logic [5:0]  day_q,   day_d;
   logic [4:0]  month_q, month_d;
   logic [13:0] year_q,  year_d;
   logic [5:0]  dim;
   logic        leap;
   logic        advance;
   logic        month_end;
   logic        year_end;

   // Returns {carry, digit}; digits above 9 behave as 9 so bad loads converge.
   function automatic logic [4:0] bcd_inc(input logic [3:0] d);
      if (d >= 4'd9) return 5'b1_0000;
      else           return {1'b0, d + 4'd1};
   endfunction

   function automatic logic div4(input logic [3:0] x, input logic [3:0] y);
      if (!x[0]) return (y == 4'd0) || (y == 4'd4) || (y == 4'd8);
      else       return (y == 4'd2) || (y == 4'd6);
   endfunction

   function automatic logic [5:0] day_inc(input logic [5:0] d);
      logic [4:0] r0;
      logic [1:0] tens;
      r0   = bcd_inc(d[3:0]);
      tens = d[5:4] + {1'b0, r0[4]};
      return {tens, r0[3:0]};
   endfunction

   // Only reached for months below 0x12, so the tens bit never overflows.
   function automatic logic [4:0] month_inc(input logic [4:0] m);
      logic [4:0] r0;
      r0 = bcd_inc(m[3:0]);
      return {m[4] | r0[4], r0[3:0]};
   endfunction

   function automatic logic [13:0] year_inc(input logic [13:0] y);
      logic [4:0] r0, r1, r2;
      logic [1:0] th;
      r0 = bcd_inc(y[3:0]);
      r1 = r0[4] ? bcd_inc(y[7:4])  : {1'b0, y[7:4]};
      r2 = r1[4] ? bcd_inc(y[11:8]) : {1'b0, y[11:8]};
      th = y[13:12] + {1'b0, r2[4]};
      return {th, r2[3:0], r1[3:0], r0[3:0]};
   endfunction

   // Century years are leap only when the century itself is divisible by 4.
   assign leap = (year_q[7:0] == 8'h00) ? div4({2'b00, year_q[13:12]}, year_q[11:8])
                                        : div4(year_q[7:4], year_q[3:0]);

   always_comb begin
      case (month_q)
         5'h02:                      dim = leap ? 6'h29 : 6'h28;
         5'h04, 5'h06, 5'h09, 5'h11: dim = 6'h30;
         default:                    dim = 6'h31;
      endcase
   end

   assign advance     = new_day_i & ~date_update_i;
   assign month_end   = (day_q >= dim);
   assign year_end    = (month_q >= 5'h12);
   assign new_month_o = advance & month_end;
   assign new_year_o  = advance & month_end & year_end;

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      day_d   = day_q;
      month_d = month_q;
      year_d  = year_q;
      if (date_update_i) begin
         day_d   = date_i[5:0];
         month_d = date_i[12:8];
         year_d  = date_i[29:16];
      end else if (new_day_i) begin
         if (month_end) begin
            day_d = 6'h01;
            if (year_end) begin
               month_d = 5'h01;
               year_d  = year_inc(year_q);
            end else begin
               month_d = month_inc(month_q);
            end
         end else begin
            day_d = day_inc(day_q);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rstn_i) begin
         day_q   <= 6'h01;
         month_q <= 5'h01;
         year_q  <= 14'h2000;
      end else begin
         day_q   <= day_d;
         month_q <= month_d;
         year_q  <= year_d;
      end
   end

   assign date_o = {2'b00, year_q, 3'b000, month_q, 2'b00, day_q};

`ifdef RTC_DATE_WEEKDAY_EN
   logic [2:0] weekday_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         weekday_q <= 3'd6;
      end else if (date_update_i) begin
         weekday_q <= weekday_i;
      end else if (new_day_i) begin
         weekday_q <= (weekday_q >= 3'd6) ? 3'd0 : weekday_q + 3'd1;
      end
   end

   assign weekday_o = weekday_q;

   logic unused_pad;
   assign unused_pad = ^{date_i[31:30], date_i[15:13], date_i[7:6]};
`else
   assign weekday_o = 3'd0;

   logic unused_pad;
   assign unused_pad = ^{date_i[31:30], date_i[15:13], date_i[7:6], weekday_i};
`endif

endmodule
